// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, FSM state type and index-width helper for the serial BCD adder
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int idx_w(input int digits);
    return digits > 1 ? $clog2(digits) : 1;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: single-digit BCD adder stage with decimal correction
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] s_d,
  output logic       c_out
);
  logic [4:0] raw;
  assign raw = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_in};
  assign c_out = raw > {1'b0, BCD_MAX};
  assign s_d = c_out ? raw[3:0] + BCD_CORR : raw[3:0];
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: multi-digit BCD adder reusing one digit stage, LSD first, one digit per clock
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      err
);
  localparam int W = DIGIT_W * DIGITS;
  localparam int IW = idx_w(DIGITS);
  state_t state, state_nx;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, last, bad, c_d;
  logic [3:0] s_d;
  bcd_digit_add u_digit (
    .a_d  (a_r[int'(idx)*DIGIT_W +: DIGIT_W]),
    .b_d  (b_r[int'(idx)*DIGIT_W +: DIGIT_W]),
    .c_in (carry),
    .s_d  (s_d),
    .c_out(c_d)
  );
  assign last = idx == IW'(DIGITS - 1);
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) | (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX);
  end
  always_comb state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_r <= a;
        b_r <= b;
        carry <= cin;
        idx <= '0;
        err <= bad;
        sum <= '0;
        cout <= 1'b0;
        busy <= 1'b1;
      end else if (state == RUN) begin
        sum[int'(idx)*DIGIT_W +: DIGIT_W] <= s_d;
        carry <= c_d;
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          cout <= c_d;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end
endmodule
